arbiter_8way_rr_chip: RTL and testbench



---
 rtl/arbiter_8way_rr_chip.sv | 149 ++++++++++++++
 tb/tb_arbiter_8way_rr_chip.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/arbiter_8way_rr_chip.sv
// Round-robin arbiter/sequencer granting one of eight requesters to a shared 1-bit demux path.
// Latency: grant registered 1 cycle after a request is seen in IDLE; 3-cycle minimum switchover.
// Backpressure: none; level-sensitive requests; optional hold timeout via `ifdef ARB_TIMEOUT_EN.
module arbiter_8way_rr_chip #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [2:0] sel,
    output logic       en,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] owner, owner_nxt;
    logic [2:0] last, last_nxt;
    logic [2:0] sel_nxt;
    logic       en_nxt;
    logic [7:0] gnt_nxt;
    logic       busy_nxt;
    logic       preempt_nxt;

    logic [2:0] pick;
    logic       pick_vld;
    logic       timeout;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt, hold_cnt_nxt;

    // Hold counter: zero on entry to GRANT, counts each cycle the grant stays live.
    always_comb begin
        hold_cnt_nxt = 8'd0;
        if (state == GRANT && state_nxt == GRANT) begin
            hold_cnt_nxt = hold_cnt + 8'd1;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= 8'd0;
        end else begin
            hold_cnt <= hold_cnt_nxt;
        end
    end

    assign timeout = (hold_cnt == 8'(MAX_HOLD - 1));
`else
    // MAX_HOLD has no role without the timeout; keep it referenced.
    logic max_hold_unused;
    assign max_hold_unused = (MAX_HOLD > 0);
    assign timeout         = 1'b0;
`endif

    // Round-robin pick: first set request scanning upward from last+1, wrapping; last is scanned last.
    always_comb begin
        logic [2:0] idx;
        idx      = 3'd0;
        pick     = 3'd0;
        pick_vld = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = last + 3'(i);
            if (!pick_vld && req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        last_nxt    = last;
        sel_nxt     = sel;
        en_nxt      = 1'b0;
        gnt_nxt     = 8'h00;
        busy_nxt    = 1'b0;
        preempt_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = GRANT;
                    owner_nxt = pick;
                    sel_nxt   = pick;
                    en_nxt    = 1'b1;
                    gnt_nxt   = 8'h01 << pick;
                    busy_nxt  = 1'b1;
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    // Voluntary release; sel keeps the old owner through GAP.
                    last_nxt  = owner;
                    state_nxt = GAP;
                end else if (timeout) begin
                    // Hold limit reached while still requesting: revoke.
                    last_nxt    = owner;
                    state_nxt   = GAP;
                    preempt_nxt = 1'b1;
                end else begin
                    sel_nxt  = owner;
                    en_nxt   = 1'b1;
                    gnt_nxt  = 8'h01 << owner;
                    busy_nxt = 1'b1;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, pointer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= 3'd0;
            last    <= 3'd7;
            sel     <= 3'd0;
            en      <= 1'b0;
            gnt     <= 8'h00;
            busy    <= 1'b0;
            preempt <= 1'b0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            last    <= last_nxt;
            sel     <= sel_nxt;
            en      <= en_nxt;
            gnt     <= gnt_nxt;
            busy    <= busy_nxt;
            preempt <= preempt_nxt;
        end
    end

endmodule

// File: tb/tb_arbiter_8way_rr_chip.sv
// Directed bench for the 8-way round-robin arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
// Each scenario task carries its own hand-computed expectations.
module tb_arbiter_8way_rr_chip;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [2:0] sel;
    logic       en;
    logic [7:0] gnt;
    logic       busy;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arbiter_8way_rr_chip #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .sel     (sel),
        .en      (en),
        .gnt     (gnt),
        .busy    (busy),
        .preempt (preempt)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req   = 8'h00;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        req   = 8'hFF;
        tick;
        tick;
        checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt got=%h exp=%h", gnt, 8'h00); end
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", en); end
        checks++; if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (preempt !== 1'b0) begin errors++; $display("FAIL reset_preempt got=%b exp=0", preempt); end
        rst_n = 1'b1;
        tick;
        checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL reset_first_gnt got=%h exp=%h", gnt, 8'h01); end
        checks++; if (en !== 1'b1 || busy !== 1'b1 || sel !== 3'd0) begin errors++; $display("FAIL reset_first_ctl en=%b busy=%b sel=%0d exp en=1 busy=1 sel=0", en, busy, sel); end
        req = 8'h00;
        tick;
        tick;
    endtask

    task automatic test_single;
        do_reset;
        req = 8'h08;
        tick;
        checks++; if (sel !== 3'd3 || en !== 1'b1 || gnt !== 8'h08) begin errors++; $display("FAIL single_grant sel=%0d en=%b gnt=%h exp sel=3 en=1 gnt=08", sel, en, gnt); end
        tick;
        checks++; if (gnt !== 8'h08 || busy !== 1'b1) begin errors++; $display("FAIL single_hold gnt=%h busy=%b exp gnt=08 busy=1", gnt, busy); end
        req = 8'h00;
        tick;
        checks++; if (en !== 1'b0 || gnt !== 8'h00 || sel !== 3'd3 || busy !== 1'b0) begin errors++; $display("FAIL single_gap en=%b gnt=%h sel=%0d busy=%b exp en=0 gnt=00 sel=3 busy=0", en, gnt, sel, busy); end
        tick;
        checks++; if (en !== 1'b0 || gnt !== 8'h00) begin errors++; $display("FAIL single_idle en=%b gnt=%h exp en=0 gnt=00", en, gnt); end
    endtask

    task automatic test_fairness;
        logic [7:0] exp_gnt [4];
        exp_gnt = '{8'h01, 8'h20, 8'h01, 8'h20};
        do_reset;
        req = 8'h21;
        tick;
        for (int k = 0; k < 4; k++) begin
            checks++; if (gnt !== exp_gnt[k]) begin errors++; $display("FAIL fair_grant%0d got=%h exp=%h", k, gnt, exp_gnt[k]); end
            tick;
            checks++; if (gnt !== exp_gnt[k]) begin errors++; $display("FAIL fair_hold%0d got=%h exp=%h", k, gnt, exp_gnt[k]); end
            req = 8'h21 & ~exp_gnt[k];
            tick;
            checks++; if (gnt !== 8'h00 || en !== 1'b0) begin errors++; $display("FAIL fair_gap%0d gnt=%h en=%b exp gnt=00 en=0", k, gnt, en); end
            req = 8'h21;
            tick;
            checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL fair_idle%0d got=%h exp=00", k, gnt); end
            tick;
        end
    endtask

    task automatic test_wrap;
        do_reset;
        req = 8'h40;
        tick;
        checks++; if (gnt !== 8'h40) begin errors++; $display("FAIL wrap_setup got=%h exp=40", gnt); end
        req = 8'h00;
        tick;
        tick;
        req = 8'h81;
        tick;
        checks++; if (gnt !== 8'h80 || sel !== 3'd7) begin errors++; $display("FAIL wrap_first gnt=%h sel=%0d exp gnt=80 sel=7", gnt, sel); end
        req = 8'h01;
        tick;
        checks++; if (gnt !== 8'h00 || sel !== 3'd7) begin errors++; $display("FAIL wrap_gap gnt=%h sel=%0d exp gnt=00 sel=7", gnt, sel); end
        tick;
        tick;
        checks++; if (gnt !== 8'h01 || sel !== 3'd0) begin errors++; $display("FAIL wrap_second gnt=%h sel=%0d exp gnt=01 sel=0", gnt, sel); end
        req = 8'h00;
        tick;
    endtask

    task automatic test_timeout;
        do_reset;
        req = 8'h06;
        tick;
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            checks++; if (gnt !== 8'h02 || preempt !== 1'b0) begin errors++; $display("FAIL tmo_hold%0d gnt=%h preempt=%b exp gnt=02 preempt=0", k, gnt, preempt); end
            tick;
        end
        checks++; if (gnt !== 8'h00 || preempt !== 1'b1) begin errors++; $display("FAIL tmo_revoke gnt=%h preempt=%b exp gnt=00 preempt=1", gnt, preempt); end
        tick;
        checks++; if (gnt !== 8'h00 || preempt !== 1'b0) begin errors++; $display("FAIL tmo_idle gnt=%h preempt=%b exp gnt=00 preempt=0", gnt, preempt); end
        tick;
        checks++; if (gnt !== 8'h04 || sel !== 3'd2) begin errors++; $display("FAIL tmo_next gnt=%h sel=%0d exp gnt=04 sel=2", gnt, sel); end
`else
        for (int k = 0; k < 20; k++) begin
            checks++; if (gnt !== 8'h02 || preempt !== 1'b0) begin errors++; $display("FAIL notmo_hold%0d gnt=%h preempt=%b exp gnt=02 preempt=0", k, gnt, preempt); end
            tick;
        end
`endif
        req = 8'h00;
        tick;
    endtask

    task automatic test_reset_mid_grant;
        do_reset;
        req = 8'h10;
        tick;
        checks++; if (gnt !== 8'h10) begin errors++; $display("FAIL midrst_setup got=%h exp=10", gnt); end
        rst_n = 1'b0;
        #1;
        checks++; if (gnt !== 8'h00 || en !== 1'b0 || sel !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_async gnt=%h en=%b sel=%0d busy=%b exp 00/0/0/0", gnt, en, sel, busy); end
        req = 8'h18;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        checks++; if (gnt !== 8'h08 || sel !== 3'd3) begin errors++; $display("FAIL midrst_next gnt=%h sel=%0d exp gnt=08 sel=3", gnt, sel); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_fairness;
        test_wrap;
        test_timeout;
        test_reset_mid_grant;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
